// File: rtl/opl_cmd_pkg.sv
// Shared definitions for the UART-to-OPL2 command parser: defaults, field width
// and the frame FSM state encoding.
package opl_cmd_pkg;

  localparam logic [7:0] HEADER_DEF     = 8'hA5;
  localparam int         FIFO_DEPTH_DEF = 4;
  localparam int         FIELD_W        = 8;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_ADDR = 2'd1;
  localparam state_t S_DATA = 2'd2;
  localparam state_t S_CHK  = 2'd3;

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead command FIFO. Pointers carry one extra wrap bit so full and empty
// are told apart without a separate occupancy counter.
module cmd_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop on an empty FIFO is ignored; a full FIFO still takes a push if the
  // head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; pointers wrap modulo 2*DEPTH through natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are meaningless while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_opl_cmd_parser.sv
// Parses HEADER/ADDR/DATA/CHK frames from a byte receiver, queues valid OPL2
// register writes in a show-ahead FIFO and keeps error/overflow status.
module uart_opl_cmd_parser
  import opl_cmd_pkg::*;
#(
  parameter logic [7:0] HEADER     = HEADER_DEF,
  parameter int         FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rx_ready,
  input  logic [FIELD_W-1:0] rx_data,
  input  logic               rx_eop,
  output logic               wr_valid,
  output logic [FIELD_W-1:0] wr_addr,
  output logic [FIELD_W-1:0] wr_data,
  input  logic               wr_ready,
  output logic [7:0]         err_cnt,
  output logic               ovf,
  input  logic               clr_status
);

  state_t             state;
  logic [FIELD_W-1:0] frame_addr;
  logic [FIELD_W-1:0] frame_data;
  logic               byte_take;
  logic               chk_ok;
  logic               push;
  logic               pop;
  logic               err_inc;
  logic               fifo_full;
  logic               fifo_empty;
  logic [2*FIELD_W-1:0] head;

  // End-of-packet wins over a byte strobe in the same cycle.
  assign byte_take = rx_ready && !rx_eop;
  assign chk_ok    = (rx_data == (frame_addr ^ frame_data));
  assign push      = byte_take && (state == S_CHK) && chk_ok;
  assign pop       = wr_valid && wr_ready;
  assign err_inc   = (rx_eop && (state != S_IDLE)) ||
                     (byte_take && (state == S_CHK) && !chk_ok);

  assign wr_valid  = !fifo_empty;
  assign wr_addr   = head[2*FIELD_W-1:FIELD_W];
  assign wr_data   = head[FIELD_W-1:0];

  // Frame FSM: one state step per accepted byte, abort to idle on rx_eop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else if (rx_eop) begin
      state <= S_IDLE;
    end else if (rx_ready) begin
      case (state)
        S_IDLE:  state <= (rx_data == HEADER) ? S_ADDR : S_IDLE;
        S_ADDR:  state <= S_DATA;
        S_DATA:  state <= S_CHK;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Address/data capture; only read in S_CHK so left without reset.
  always_ff @(posedge clk) begin
    if (byte_take && (state == S_ADDR)) frame_addr <= rx_data;
    if (byte_take && (state == S_DATA)) frame_data <= rx_data;
  end

  // Status: saturating error count and sticky overflow, clear has priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
      ovf     <= 1'b0;
    end else if (clr_status) begin
      err_cnt <= 8'd0;
      ovf     <= 1'b0;
    end else begin
      if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
      if (push && fifo_full && !pop)     ovf     <= 1'b1;
    end
  end

  cmd_fifo #(
    .WIDTH (2*FIELD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({frame_addr, frame_data}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_uart_opl_cmd_parser.sv
// Directed bench for uart_opl_cmd_parser: frame parsing, error counting,
// FIFO ordering/overflow and reset behaviour.
module tb_uart_opl_cmd_parser;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_eop;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic [7:0] err_cnt;
  logic       ovf;
  logic       clr_status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_opl_cmd_parser dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_eop     (rx_eop),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .err_cnt    (err_cnt),
    .ovf        (ovf),
    .clr_status (clr_status)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle byte strobe; returns at the negedge after the capturing posedge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
    send_byte(8'hA5);
    send_byte(a);
    send_byte(d);
    send_byte(c);
  endtask

  task automatic pulse_eop();
    @(negedge clk);
    rx_eop = 1'b1;
    @(negedge clk);
    rx_eop = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr_status = 1'b1;
    @(negedge clk);
    clr_status = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; rx_ready = 1'b0; rx_data = 8'h00; rx_eop = 1'b0;
    wr_ready = 1'b1; clr_status = 1'b0;
    #12;
    check("rst_valid", wr_valid, 0);
    check("rst_addr",  wr_addr,  0);
    check("rst_data",  wr_data,  0);
    check("rst_err",   err_cnt,  0);
    check("rst_ovf",   ovf,      0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single valid frame, one-cycle write.
    send_frame(8'h12, 8'h34, 8'h26);
    check("f1_valid", wr_valid, 1);
    check("f1_addr",  wr_addr,  8'h12);
    check("f1_data",  wr_data,  8'h34);
    @(negedge clk);
    check("f1_pulse", wr_valid, 0);
    check("f1_err",   err_cnt,  0);

    // Bad checksum, then a good frame.
    send_frame(8'h12, 8'h34, 8'h27);
    check("bad_valid", wr_valid, 0);
    check("bad_err",   err_cnt,  1);
    send_frame(8'h01, 8'h02, 8'h03);
    check("f2_valid", wr_valid, 1);
    check("f2_addr",  wr_addr,  8'h01);
    check("f2_data",  wr_data,  8'h02);
    @(negedge clk);

    // Abort mid-frame, FSM must be back in idle.
    send_byte(8'hA5);
    send_byte(8'h12);
    pulse_eop();
    check("eop_err", err_cnt, 2);
    send_frame(8'h56, 8'h78, 8'h2E);
    check("eop_idle_valid", wr_valid, 1);
    check("eop_idle_addr",  wr_addr,  8'h56);
    @(negedge clk);
    pulse_eop();
    check("eop_idle_err", err_cnt, 2);

    // eop together with a byte in S_ADDR: byte dropped, error counted.
    send_byte(8'hA5);
    @(negedge clk);
    rx_ready = 1'b1; rx_data = 8'h99; rx_eop = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0; rx_eop = 1'b0;
    check("eop_prio_err", err_cnt, 3);

    // Fill with ready low: four held, fifth dropped.
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send_frame(8'h10 + 8'(i), 8'h20 + 8'(i), (8'h10 + 8'(i)) ^ (8'h20 + 8'(i)));
    check("full_ovf",   ovf,      1);
    check("full_valid", wr_valid, 1);
    repeat (3) @(negedge clk);
    check("hold_addr", wr_addr, 8'h10);
    check("hold_data", wr_data, 8'h20);
    wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", wr_valid, 1);
      check("drain_addr",  wr_addr,  8'h10 + 8'(i));
      check("drain_data",  wr_data,  8'h20 + 8'(i));
      @(negedge clk);
    end
    check("drain_empty", wr_valid, 0);
    pulse_clr();
    check("clr_ovf", ovf,     0);
    check("clr_err", err_cnt, 0);

    // Push into a full FIFO with a same-cycle pop.
    wr_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      send_frame(8'h30 + 8'(i), 8'h40 + 8'(i), (8'h30 + 8'(i)) ^ (8'h40 + 8'(i)));
    send_byte(8'hA5);
    send_byte(8'h34);
    send_byte(8'h44);
    @(negedge clk);
    rx_ready = 1'b1; rx_data = 8'h34 ^ 8'h44; wr_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0; wr_ready = 1'b0;
    check("pp_ovf",  ovf,     0);
    check("pp_head", wr_addr, 8'h31);
    wr_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("pp_valid", wr_valid, 1);
      check("pp_addr",  wr_addr,  8'h30 + 8'(i));
      check("pp_data",  wr_data,  8'h40 + 8'(i));
      @(negedge clk);
    end
    check("pp_empty", wr_valid, 0);

    // Error counter saturation.
    for (int i = 0; i < 300; i++) send_frame(8'h00, 8'h00, 8'h01);
    check("sat_err", err_cnt, 8'hFF);
    pulse_clr();
    check("sat_clr", err_cnt, 0);

    // Reset with queued entries and a partial frame.
    wr_ready = 1'b0;
    send_frame(8'h50, 8'h60, 8'h30);
    send_frame(8'h51, 8'h61, 8'h30);
    check("pre_rst_valid", wr_valid, 1);
    send_byte(8'hA5);
    send_byte(8'h12);
    send_byte(8'h34);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", wr_valid, 0);
    check("mid_rst_addr",  wr_addr,  0);
    @(negedge clk);
    rst_n = 1'b1;
    wr_ready = 1'b1;
    send_byte(8'h26);
    check("post_rst_valid", wr_valid, 0);
    repeat (2) @(negedge clk);
    check("post_rst_idle", wr_valid, 0);
    send_frame(8'h77, 8'h11, 8'h66);
    check("post_rst_addr", wr_addr, 8'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
